// File: rtl/cac_enc_5_seq_pkg.sv
// Shared constants and state encodings for the 5-bit FNS crosstalk-avoidance
// encoder. The decoder uses the same constants, so the two always agree on widths.
package cac_enc_5_seq_pkg;

  localparam int BLEN_05   = 4;
  localparam int FNSLEN_03 = 2;
  localparam int FNSLEN_04 = 2;
  localparam int FNSLEN_05 = 3;

  // Compare/subtract width: the binary input and the widest weight both fit.
  localparam int CMP_W = (BLEN_05 > FNSLEN_05) ? BLEN_05 : FNSLEN_05;

  localparam int CODE_W = 5;
  localparam logic [2:0] IDX_MSB = 3'd4;

  typedef enum logic [1:0] {
    CACENC_IDLE = 2'd0,
    CACENC_ENC  = 2'd1,
    CACENC_DONE = 2'd2
  } cacenc_state_e;

endpackage

// File: rtl/cac_enc_5_seq_bitstep.sv
// One greedy FNS step: emit a code bit if the remainder covers the weight,
// and return the remainder left after that decision.
module cac_enc_5_seq_bitstep
  import cac_enc_5_seq_pkg::*;
(
  input  logic [CMP_W-1:0] rem,
  input  logic [CMP_W-1:0] weight,
  output logic             code_bit,
  output logic [CMP_W-1:0] rem_next
);

  // The subtraction is only selected when rem >= weight, so it cannot wrap.
  assign code_bit = (rem >= weight);
  assign rem_next = code_bit ? (rem - weight) : rem;

endmodule

// File: rtl/cac_enc_5_seq.sv
// Sequential 5-bit FNS crosstalk-avoidance encoder, one code bit per clock,
// MSB first. Optional range check is enabled with CAC_ENC_RANGE_CHECK_EN.
module cac_enc_5_seq
  import cac_enc_5_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLEN_05-1:0]   datain,
  input  logic [FNSLEN_03-1:0] FNS03,
  input  logic [FNSLEN_04-1:0] FNS04,
  input  logic [FNSLEN_05-1:0] FNS05,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CODE_W-1:0]    codeout,
  output logic                 err
);

  cacenc_state_e state_q, state_d;

  logic [CMP_W-1:0]  rem_q;
  logic [CMP_W-1:0]  w2_q, w3_q, w4_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] codeout_q;
  logic [2:0]        idx_q;

  logic [CMP_W-1:0]  sel_weight;
  logic              step_bit;
  logic [CMP_W-1:0]  step_rem;
  logic [CODE_W-1:0] code_next;
  logic              accept;
  logic              last_step;

  assign accept    = in_valid & in_ready;
  assign last_step = (state_q == CACENC_ENC) && (idx_q == 3'd0);

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= CACENC_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CACENC_IDLE: if (accept)    state_d = CACENC_ENC;
      CACENC_ENC:  if (last_step) state_d = CACENC_DONE;
      CACENC_DONE: if (out_ready) state_d = accept ? CACENC_ENC : CACENC_IDLE;
      default:                    state_d = CACENC_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      CACENC_IDLE: in_ready = 1'b1;
      CACENC_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    sel_weight = '0;
    case (idx_q)
      3'd4:    sel_weight = w4_q;
      3'd3:    sel_weight = w3_q;
      3'd2:    sel_weight = w2_q;
      default: sel_weight = CMP_W'(1);
    endcase
  end

  cac_enc_5_seq_bitstep u_bitstep (
    .rem      (rem_q),
    .weight   (sel_weight),
    .code_bit (step_bit),
    .rem_next (step_rem)
  );

  always_comb begin
    code_next        = code_q;
    code_next[idx_q] = step_bit;
  end

  // NOTE: the weight registers are not reset; they are loaded on every accept
  // before anything reads them, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    if (accept) begin
      w2_q <= CMP_W'(FNS03);
      w3_q <= CMP_W'(FNS04);
      w4_q <= CMP_W'(FNS05);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      code_q    <= '0;
      codeout_q <= '0;
      idx_q     <= IDX_MSB;
    end else if (accept) begin
      rem_q  <= CMP_W'(datain);
      code_q <= '0;
      idx_q  <= IDX_MSB;
    end else if (state_q == CACENC_ENC) begin
      rem_q  <= step_rem;
      code_q <= code_next;
      idx_q  <= last_step ? IDX_MSB : (idx_q - 3'd1);
      // The visible codeword only moves on the edge that enters DONE.
      if (last_step) codeout_q <= code_next;
    end
  end

  assign codeout = codeout_q;

`ifdef CAC_ENC_RANGE_CHECK_EN
  logic err_q;

  // Any remainder left after the unit-weight bits means the input was too big.
  always_ff @(posedge clk) begin
    if (rst)            err_q <= 1'b0;
    else if (accept)    err_q <= 1'b0;
    else if (last_step) err_q <= (step_rem != '0);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cac_enc_5_seq.sv
// Directed bench for cac_enc_5_seq: reset state, latency, greedy codewords,
// round trip through a weighted-sum decoder model, backpressure and abort.
module tb_cac_enc_5_seq;
  import cac_enc_5_seq_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [BLEN_05-1:0]   datain;
  logic [FNSLEN_03-1:0] FNS03;
  logic [FNSLEN_04-1:0] FNS04;
  logic [FNSLEN_05-1:0] FNS05;
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           codeout;
  logic                 err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cac_enc_5_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .FNS03     (FNS03),
    .FNS04     (FNS04),
    .FNS05     (FNS05),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeout   (codeout),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Weighted sum of a codeword with weights 1,1,2,3,5 (the decoder model).
  function automatic int decode(input logic [4:0] c);
    return c[0] + c[1] + 2 * c[2] + 3 * c[3] + 5 * c[4];
  endfunction

  // Wait for out_valid after an accept edge; returns cycles taken (bounded).
  task automatic wait_out(output int lat);
    lat = 1;
    step();
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // Accept one word with out_ready held high and check latency and codeword.
  task automatic run_word(input string tag, input logic [3:0] d,
                          input logic [4:0] exp_code, input logic exp_err,
                          input bit scramble);
    int lat;
    in_valid  = 1'b1;
    datain    = d;
    out_ready = 1'b1;
    step();                       // accept edge E0
    in_valid = 1'b0;
    datain   = 4'hf;
    if (scramble) begin
      FNS03 = 2'd0; FNS04 = 2'd0; FNS05 = 3'd0;
    end
    wait_out(lat);
    check({tag, "_lat"},  lat, 5);
    check({tag, "_code"}, codeout, exp_code);
    check({tag, "_err"},  err, exp_err);
    check({tag, "_rt"},   decode(codeout), exp_err ? decode(exp_code) : d);
    FNS03 = 2'd2; FNS04 = 2'd3; FNS05 = 3'd5;
    step();                       // output transfers, back to IDLE
  endtask

  initial begin
    int lat;
    int seen;
    logic [4:0] ex_code;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; datain = '0;
    FNS03 = 2'd2; FNS04 = 2'd3; FNS05 = 3'd5;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_codeout",   codeout, 0);
    check("rst_err",       err, 0);

    run_word("d12", 4'd12, 5'b11111, 1'b0, 1'b0);
    run_word("d7",  4'd7,  5'b10100, 1'b0, 1'b1);  // weights changed mid-encode
    run_word("d0",  4'd0,  5'b00000, 1'b0, 1'b0);
    run_word("d1",  4'd1,  5'b00010, 1'b0, 1'b0);  // bit 1 resolves before bit 0

    // Exhaustive in-range round trip, expected codes from a greedy model.
    for (int v = 0; v <= 12; v++) begin
      int r;
      int w[5];
      r = v;
      w[0] = 1; w[1] = 1; w[2] = 2; w[3] = 3; w[4] = 5;
      for (int b = 4; b >= 0; b--) begin
        ex_code[b] = (r >= w[b]);
        if (ex_code[b]) r -= w[b];
      end
      run_word($sformatf("ex%0d", v), 4'(v), ex_code, 1'b0, 1'b0);
    end

    // Backpressure: 9 -> 11010 held, then back-to-back accept of 3 -> 01000.
    in_valid = 1'b1; datain = 4'd9; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    check("bp_lat", lat, 5);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_code",  codeout, 5'b11010);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready",   in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b1; datain = 4'd3;
    #1;
    check("bp_ready_comb", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_accepted",    out_valid, 0);
    check("bp_code_stable", codeout, 5'b11010);
    wait_out(lat);
    check("bp2_lat",  lat, 5);
    check("bp2_code", codeout, 5'b01000);
    step();

    // Reset while idx=2 is being resolved: word discarded, never presented.
    in_valid = 1'b1; datain = 4'd12;
    step();                       // E0 accept
    in_valid = 1'b0;
    step();                       // E1 bit 4
    step();                       // E2 bit 3, now resolving idx=2
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready",  in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_codeout",   codeout, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);

`ifdef CAC_ENC_RANGE_CHECK_EN
    run_word("ovf13", 4'd13, 5'b11111, 1'b1, 1'b0);
    run_word("after_ovf4", 4'd4, 5'b01010, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
